d8_fetch: RTL and testbench

D8_FETCH -- requirements
Module: d8_fetch

---
 rtl/d8_fetch.sv | 137 +++++++++++++
 tb/tb_d8_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/d8_fetch.sv
// d8_fetch -- single-outstanding instruction fetch stage.
//
// Issues one read at a time to an instruction memory, buffers at most one
// returned word for the decode stage, and handles redirects (jmp). A redirect
// never cancels a request the memory is already working on. The stage waits
// for that request's ack, drops the data, and then fetches from the target.
//
// Ports
//   sys_clk      in   clock; all state changes on the rising edge
//   sys_rst_n    in   asynchronous active-low reset
//   im_addr      out  [ADDR_W] instruction-memory word address (held per request)
//   im_req       out  read request, high in FETCH and FLUSH
//   im_ack       in   read completion; im_data is valid in the same cycle
//   im_data      in   [32] instruction word from memory
//   instr        out  [32] buffered instruction for decode
//   instr_pc     out  [ADDR_W] address instr was fetched from
//   instr_valid  out  instr/instr_pc hold an unconsumed instruction
//   instr_ready  in   decode accepts instr this cycle
//   jmp          in   one-cycle redirect strobe
//   jmp_addr     in   [ADDR_W] redirect target, sampled when jmp=1
module d8_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic [ADDR_W-1:0] im_addr,
  output logic              im_req,
  input  logic              im_ack,
  input  logic [31:0]       im_data,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr
);

  // FLUSH means a request is still in flight at the old address. Its data
  // is dropped on ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_im_addr;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;

  // Natural-width addition wraps all-ones back to zero.
  assign w_pc_inc = r_pc + PC_ONE;
  // The next fetch address is the jump target if one arrives this cycle,
  // otherwise the stored pc.
  assign w_target = jmp ? jmp_addr : r_pc;

  // NOTE: every register below uses non-blocking assignments. All state
  // updates then read the values from before the edge, whatever the order
  // of the statements.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_im_addr     <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_pc      <= w_target;
          r_im_addr <= w_target;
          r_state   <= FETCH;
        end

        FETCH: begin
          if (im_ack && !jmp) begin
            r_instr       <= im_data;
            r_instr_pc    <= r_im_addr;
            r_instr_valid <= 1'b1;
            r_pc          <= w_pc_inc;
            r_state       <= HOLD;
          end else if (im_ack && jmp) begin
            // The returned word belongs to the abandoned path. A fresh
            // request to the target starts next cycle.
            r_pc      <= jmp_addr;
            r_im_addr <= jmp_addr;
          end else if (jmp) begin
            // The request in flight keeps its address until the ack arrives.
            r_pc    <= jmp_addr;
            r_state <= FLUSH;
          end
        end

        FLUSH: begin
          // If several jumps arrive before the ack, the most recent one is used.
          r_pc <= w_target;
          if (im_ack) begin
            r_im_addr <= w_target;
            r_state   <= FETCH;
          end
        end

        HOLD: begin
          if (jmp) begin
            r_instr_valid <= 1'b0;
            r_pc          <= jmp_addr;
            r_im_addr     <= jmp_addr;
            r_state       <= FETCH;
          end else if (instr_ready) begin
            r_instr_valid <= 1'b0;
            r_im_addr     <= r_pc;
            r_state       <= FETCH;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign im_req      = (r_state == FETCH) || (r_state == FLUSH);
  assign im_addr     = r_im_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_d8_fetch.sv
// Directed bench for d8_fetch (ADDR_W=8, RESET_PC=0).
// Inputs change 1 ns after a rising edge, and outputs are sampled at that
// same point. Each value sampled is therefore the state left by that edge.
module tb_d8_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  im_addr;
  logic        im_req;
  logic        im_ack;
  logic [31:0] im_data;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jmp;
  logic [7:0]  jmp_addr;

  // When auto_mem is set, the bench acts as a zero-wait memory that acks
  // every request in the cycle it is made.
  logic        auto_mem;
  logic        man_ack;
  logic [31:0] man_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] word(input logic [7:0] a);
    return {a, ~a, 8'h3C, a ^ 8'h5A};
  endfunction

  assign im_ack  = auto_mem ? im_req : man_ack;
  assign im_data = auto_mem ? word(im_addr) : man_data;

  d8_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .im_addr     (im_addr),
    .im_req      (im_req),
    .im_ack      (im_ack),
    .im_data     (im_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp         (jmp),
    .jmp_addr    (jmp_addr)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Leaves the DUT in FETCH at address 0 with all bench inputs idle.
  task automatic do_reset();
    auto_mem = 1'b0; man_ack = 1'b0; man_data = '0;
    instr_ready = 1'b0; jmp = 1'b0; jmp_addr = '0;
    sys_rst_n = 1'b0;
    step(); step();
    sys_rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    auto_mem = 1'b0; man_ack = 1'b0; man_data = '0;
    instr_ready = 1'b0; jmp = 1'b0; jmp_addr = '0;
    sys_rst_n = 1'b0;
    #3;
    total_cnt++;
    if ({im_req, im_addr, instr, instr_pc, instr_valid} !== 50'd0)
      $display("FAIL reset_outputs: got req=%b addr=%h instr=%h pc=%h v=%b want all zero",
               im_req, im_addr, instr, instr_pc, instr_valid);
    else pass_cnt++;
    step(); step();
    sys_rst_n = 1'b1;
    #1;
    total_cnt++;
    if (im_req !== 1'b0) $display("FAIL reset_release_no_req: got %b want 0", im_req);
    else pass_cnt++;
    step();
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h00)
      $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=00", im_req, im_addr);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready = 1'b1;
    auto_mem = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (im_req !== 1'b1 || im_addr !== 8'(k))
        $display("FAIL stream_req[%0d]: got req=%b addr=%h want req=1 addr=%h", k, im_req, im_addr, 8'(k));
      else pass_cnt++;
      step();
      total_cnt++;
      if (instr_valid !== 1'b1 || instr_pc !== 8'(k) || instr !== word(8'(k)) || im_req !== 1'b0)
        $display("FAIL stream_instr[%0d]: got v=%b pc=%h instr=%h req=%b want v=1 pc=%h instr=%h req=0",
                 k, instr_valid, instr_pc, instr, im_req, 8'(k), word(8'(k)));
      else pass_cnt++;
      step();
    end
    auto_mem = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    // Redirect to 0x05 while the request to 0 is pending.
    jmp = 1'b1; jmp_addr = 8'h05;
    step();
    jmp = 1'b0;
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h00)
      $display("FAIL hold_flush_addr: got req=%b addr=%h want req=1 addr=00", im_req, im_addr);
    else pass_cnt++;
    man_ack = 1'b1; man_data = 32'hFFFF_FFFF;
    step();
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h05 || instr_valid !== 1'b0)
      $display("FAIL hold_fetch5: got req=%b addr=%h v=%b want req=1 addr=05 v=0", im_req, im_addr, instr_valid);
    else pass_cnt++;
    man_data = 32'hAB01_0203;
    step();
    // A stray ack with other data while holding must change nothing.
    man_data = 32'h1234_5678;
    for (int c = 0; c < 4; c++) begin
      total_cnt++;
      if (instr_valid !== 1'b1 || instr !== 32'hAB01_0203 || instr_pc !== 8'h05 || im_req !== 1'b0)
        $display("FAIL hold_stable[%0d]: got v=%b instr=%h pc=%h req=%b want v=1 instr=ab010203 pc=05 req=0",
                 c, instr_valid, instr, instr_pc, im_req);
      else pass_cnt++;
      step();
    end
    man_ack = 1'b0;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 8'h06)
      $display("FAIL hold_accept: got v=%b req=%b addr=%h want v=0 req=1 addr=06", instr_valid, im_req, im_addr);
    else pass_cnt++;
  endtask

  task automatic test_jmp_pending();
    do_reset();
    // An ack that coincides with a jump goes straight to a request at 0x10.
    man_ack = 1'b1; man_data = 32'h0; jmp = 1'b1; jmp_addr = 8'h10;
    step();
    man_ack = 1'b0;
    // A jump arrives while 0x10 is pending. A later jump during FLUSH must win.
    jmp_addr = 8'h30;
    step();
    jmp_addr = 8'h40;
    step();
    jmp = 1'b0;
    step();
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h10 || instr_valid !== 1'b0)
      $display("FAIL jmp_pending_addr: got req=%b addr=%h v=%b want req=1 addr=10 v=0", im_req, im_addr, instr_valid);
    else pass_cnt++;
    man_ack = 1'b1; man_data = 32'hDEAD_BEEF;
    step();
    man_ack = 1'b0;
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h40 || instr_valid !== 1'b0)
      $display("FAIL jmp_pending_next: got req=%b addr=%h v=%b want req=1 addr=40 v=0", im_req, im_addr, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_ack_jmp();
    do_reset();
    man_ack = 1'b1; man_data = 32'h0; jmp = 1'b1; jmp_addr = 8'h10;
    step();
    jmp_addr = 8'h80; man_data = 32'h1111_1111;
    step();
    jmp = 1'b0;
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h80 || instr_valid !== 1'b0)
      $display("FAIL ack_jmp_redirect: got req=%b addr=%h v=%b want req=1 addr=80 v=0", im_req, im_addr, instr_valid);
    else pass_cnt++;
    man_data = 32'h8080_0001;
    step();
    man_ack = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h80 || instr !== 32'h8080_0001)
      $display("FAIL ack_jmp_capture: got v=%b pc=%h instr=%h want v=1 pc=80 instr=80800001", instr_valid, instr_pc, instr);
    else pass_cnt++;
    instr_ready = 1'b1; jmp = 1'b1; jmp_addr = 8'h22;
    step();
    instr_ready = 1'b0; jmp = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 8'h22)
      $display("FAIL hold_jmp: got v=%b req=%b addr=%h want v=0 req=1 addr=22", instr_valid, im_req, im_addr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    man_ack = 1'b1; man_data = 32'h0; jmp = 1'b1; jmp_addr = 8'hFF;
    step();
    jmp = 1'b0; man_data = 32'hFF00_00FF;
    step();
    man_ack = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'hFF || instr !== 32'hFF00_00FF)
      $display("FAIL wrap_capture: got v=%b pc=%h instr=%h want v=1 pc=ff instr=ff0000ff", instr_valid, instr_pc, instr);
    else pass_cnt++;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h00)
      $display("FAIL wrap_next: got req=%b addr=%h want req=1 addr=00", im_req, im_addr);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    man_ack = 1'b1; man_data = 32'hCAFE_F00D;
    step();
    man_ack = 1'b0;
    total_cnt++;
    if (instr_valid !== 1'b1 || instr !== 32'hCAFE_F00D)
      $display("FAIL rst_hold_pre: got v=%b instr=%h want v=1 instr=cafef00d", instr_valid, instr);
    else pass_cnt++;
    // Assert reset between clock edges. The outputs must clear without waiting for an edge.
    #2 sys_rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({im_req, im_addr, instr, instr_pc, instr_valid} !== 50'd0)
      $display("FAIL rst_hold_async: got req=%b addr=%h instr=%h pc=%h v=%b want all zero",
               im_req, im_addr, instr, instr_pc, instr_valid);
    else pass_cnt++;
    step();
    sys_rst_n = 1'b1;
    step();
    total_cnt++;
    if (im_req !== 1'b1 || im_addr !== 8'h00 || instr_valid !== 1'b0)
      $display("FAIL rst_hold_restart: got req=%b addr=%h v=%b want req=1 addr=00 v=0", im_req, im_addr, instr_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold();
    test_jmp_pending();
    test_ack_jmp();
    test_wrap();
    test_reset_in_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
